// File: rtl/dti_pack.sv
// rtl/dti_pack.sv - shared DTI widths, request-arbiter state and beat type
package dti_pack;

  localparam int CUSTOM_DATA_WIDTH = 32;
  localparam int CUSTOM_KEEP_WIDTH = 4;
  localparam int TBU_NUM_WIDTH     = 4;
  localparam int DTI_PLD_W         = CUSTOM_DATA_WIDTH + CUSTOM_KEEP_WIDTH;
  localparam int DTI_ARB_REQ_NUM   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } dti_arb_state_e;

  typedef struct packed {
    logic [DTI_PLD_W-1:0]     payload;
    logic [TBU_NUM_WIDTH-1:0] srcid;
    logic [TBU_NUM_WIDTH-1:0] tgtid;
    logic                     qos;
    logic                     last;
  } dti_req_beat_t;

  // Index width for n requesters; a single requester still gets a 1-bit id.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dti_rr_pick.sv
// rtl/dti_rr_pick.sv - combinational round-robin pick: first request at or after ptr
module dti_rr_pick
  import dti_pack::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] j;
    logic          found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dti_tniu_req_arb.sv
// rtl/dti_tniu_req_arb.sv - packet-atomic two-level round-robin arbiter onto one TNIU REQ channel
module dti_tniu_req_arb
  import dti_pack::*;
#(
  parameter  int REQ_NUM = DTI_ARB_REQ_NUM,
  parameter  int PLD_W   = DTI_PLD_W,
  parameter  int ID_W    = TBU_NUM_WIDTH,
  localparam int GID_W   = idx_w(REQ_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_NUM-1:0]       s_valid,
  input  logic [REQ_NUM*PLD_W-1:0] s_payload,
  input  logic [REQ_NUM-1:0]       s_last,
  input  logic [REQ_NUM*ID_W-1:0]  s_srcid,
  input  logic [REQ_NUM*ID_W-1:0]  s_tgtid,
  input  logic [REQ_NUM-1:0]       s_qos,
  output logic [REQ_NUM-1:0]       s_ready,
  output logic                     m_valid,
  output logic [PLD_W-1:0]         m_payload,
  output logic                     m_last,
  output logic [ID_W-1:0]          m_srcid,
  output logic [ID_W-1:0]          m_tgtid,
  output logic                     m_qos,
  input  logic                     m_ready,
  input  logic                     m_threshold,
  output logic [GID_W-1:0]         grant_id
);

  dti_arb_state_e state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] lock_id_q, lock_id_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic             m_valid_q, m_valid_d;
  dti_req_beat_t    beat_q, beat_d, beat_in;

  logic [REQ_NUM-1:0] elig, hi, hi_gnt, el_gnt;
  logic [GID_W-1:0]   hi_idx, el_idx, pick_idx, g;
  logic               hi_any, el_any, load_en, xfer;

  // Congestion only holds back low-priority packet starts.
  assign elig = s_valid & (s_qos | {REQ_NUM{~m_threshold}});
  assign hi   = elig & s_qos;

  dti_rr_pick #(.N(REQ_NUM)) u_pick_hi (
    .req (hi),
    .ptr (rr_ptr_q),
    .gnt (hi_gnt),
    .idx (hi_idx),
    .any (hi_any)
  );

  dti_rr_pick #(.N(REQ_NUM)) u_pick_el (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (el_gnt),
    .idx (el_idx),
    .any (el_any)
  );

  assign pick_idx = hi_any ? hi_idx : el_idx;
  assign load_en  = ~m_valid_q | m_ready;
  assign g        = (state_q == ARB_LOCK) ? lock_id_q : pick_idx;

  always_comb begin
    s_ready = '0;
    if (!rst && load_en) begin
      if (state_q == ARB_LOCK) s_ready[lock_id_q] = 1'b1;
      else if (el_any)         s_ready = hi_any ? hi_gnt : el_gnt;
    end
  end

  assign xfer = |(s_valid & s_ready);

  always_comb begin
    beat_in.payload = s_payload[int'(g)*PLD_W +: PLD_W];
    beat_in.srcid   = s_srcid[int'(g)*ID_W +: ID_W];
    beat_in.tgtid   = s_tgtid[int'(g)*ID_W +: ID_W];
    beat_in.qos     = s_qos[g];
    beat_in.last    = s_last[g];
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    m_valid_d = m_valid_q;
    beat_d    = beat_q;
    if (load_en) m_valid_d = xfer;
    if (xfer) begin
      beat_d = beat_in;
      // The pointer only advances at packet boundaries so a packet is never split.
      if (beat_in.last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (g == GID_W'(REQ_NUM-1)) ? '0 : g + 1'b1;
      end else begin
        state_d   = ARB_LOCK;
        lock_id_d = g;
      end
    end
  end

  always_comb begin
    grant_id_d = grant_id_q;
    if (state_q == ARB_LOCK) grant_id_d = lock_id_q;
    else if (el_any)         grant_id_d = pick_idx;
  end

  assign grant_id = rst ? '0 : grant_id_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      grant_id_q <= '0;
      m_valid_q  <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      grant_id_q <= grant_id_d;
      m_valid_q  <= m_valid_d;
      beat_q     <= beat_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_payload = beat_q.payload;
  assign m_srcid   = beat_q.srcid;
  assign m_tgtid   = beat_q.tgtid;
  assign m_qos     = beat_q.qos;
  assign m_last    = beat_q.last;

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(s_ready));
  a_lock_qos_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_LOCK && $past(state_q) == ARB_LOCK) |-> (s_qos[lock_id_q] == $past(s_qos[lock_id_q])));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(beat_q)));
`endif

endmodule
